// File: rtl/vector_mem_unit_if.sv
// Request/response and data-memory bus of the vector memory unit.
// The master modport is the requester plus the memory; the slave is the unit itself.
interface vector_mem_unit_if #(
    parameter int ELEMS  = 16,
    parameter int ELEM_W = 16,
    parameter int ADDR_W = 16
);
    logic                      start;
    logic                      is_store;
    logic [ADDR_W-1:0]         base_addr;
    logic [ELEMS*ELEM_W-1:0]   wdata;
    logic                      busy;
    logic                      done;
    logic [ELEMS*ELEM_W-1:0]   rdata;
    logic [ADDR_W-1:0]         mem_addr;
    logic [ELEM_W-1:0]         mem_wdata;
    logic                      mem_we;
    logic                      mem_re;
    logic [ELEM_W-1:0]         mem_rdata;
    logic                      err;

    modport master (
        output start, is_store, base_addr, wdata, mem_rdata,
        input  busy, done, rdata, mem_addr, mem_wdata, mem_we, mem_re, err
    );

    modport slave (
        input  start, is_store, base_addr, wdata, mem_rdata,
        output busy, done, rdata, mem_addr, mem_wdata, mem_we, mem_re, err
    );
endinterface

// File: rtl/vector_mem_unit.sv
// VLD/VST executor: moves one vector between a register and word-wide data memory, one lane per cycle.
// Optional VMEM_WRAP_ERR_EN: err pulses with done when any lane address wrapped past the top of memory.
//
// state | meaning
// IDLE  | waiting for start
// XFER  | one memory strobe per cycle, lanes 0..ELEMS-1
// DRAIN | load only: capture the last returning word
// FIN   | single-cycle done pulse
module vector_mem_unit #(
    parameter int ELEMS  = 16,
    parameter int ELEM_W = 16,
    parameter int ADDR_W = 16
) (
    input logic               clk,
    input logic               rst,
    vector_mem_unit_if.slave  bus
);
    localparam int IDX_W = $clog2(ELEMS);
    localparam int VEC_W = ELEMS * ELEM_W;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ELEMS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, FIN} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_next;
    logic [IDX_W-1:0]   idx_prev;
    logic               is_store_q;
    logic [VEC_W-1:0]   wdata_q;

    always_comb begin
        idx_next = idx + IDX_ONE;
        idx_prev = idx - IDX_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            is_store_q    <= 1'b0;
            wdata_q       <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_re    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state         <= XFER;
                        idx           <= '0;
                        is_store_q    <= bus.is_store;
                        wdata_q       <= bus.wdata;
                        bus.busy      <= 1'b1;
                        bus.mem_addr  <= bus.base_addr;
                        bus.mem_we    <= bus.is_store;
                        bus.mem_re    <= !bus.is_store;
                        bus.mem_wdata <= bus.is_store ? bus.wdata[ELEM_W-1:0] : '0;
                    end
                end
                XFER: begin
                    // read data trails the strobe by one cycle, so lane idx-1 lands now
                    if (!is_store_q && idx != '0)
                        bus.rdata[idx_prev*ELEM_W +: ELEM_W] <= bus.mem_rdata;
                    if (idx == IDX_LAST) begin
                        bus.mem_we    <= 1'b0;
                        bus.mem_re    <= 1'b0;
                        bus.mem_wdata <= '0;
                        if (is_store_q) begin
                            state    <= FIN;
                            bus.done <= 1'b1;
                        end else begin
                            state    <= DRAIN;
                        end
                    end else begin
                        idx           <= idx_next;
                        bus.mem_addr  <= bus.mem_addr + ADDR_W'(1);
                        bus.mem_wdata <= is_store_q ? wdata_q[idx_next*ELEM_W +: ELEM_W] : '0;
                    end
                end
                DRAIN: begin
                    bus.rdata[(ELEMS-1)*ELEM_W +: ELEM_W] <= bus.mem_rdata;
                    state    <= FIN;
                    bus.done <= 1'b1;
                end
                FIN: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VMEM_WRAP_ERR_EN
    localparam logic [ADDR_W-1:0] WRAP_LIMIT = ADDR_W'((2 ** ADDR_W) - ELEMS);

    logic wrap_q;
    logic fin_next;

    assign fin_next = (state == XFER && idx == IDX_LAST && is_store_q) || (state == DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q  <= 1'b0;
            bus.err <= 1'b0;
        end else begin
            if (state == IDLE && bus.start)
                wrap_q <= bus.base_addr > WRAP_LIMIT;
            bus.err <= fin_next && wrap_q;
        end
    end
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_vector_mem_unit.sv
// Bench for vector_mem_unit: table of directed ops, back-to-back/ignored-start/reset corner
// sequences, then random ops checked against a word-addressed reference memory.
module tb_vector_mem_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    vector_mem_unit_if bus();

    vector_mem_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef VMEM_WRAP_ERR_EN
    localparam bit WRAP_ON = 1'b1;
`else
    localparam bit WRAP_ON = 1'b0;
`endif

    logic [15:0]  mem     [0:65535];
    logic [15:0]  ref_mem [0:65535];
    logic [255:0] last_rd;

    // data memory seen by the DUT: fixed one-cycle read latency, junk when not reading
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= bus.mem_re ? mem[bus.mem_addr] : 16'($urandom);
    end

    typedef struct {
        bit          st;
        logic [15:0] base;
        logic [15:0] pat;
        int          done_cyc;
        bit          err;
    } vec_t;

    vec_t tbl [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] pat_vec(input logic [15:0] pat);
        logic [255:0] v;
        for (int i = 0; i < 16; i++) v[16*i +: 16] = 16'(pat + 16'(i));
        return v;
    endfunction

    function automatic int exp_done(input bit st);
        return st ? 17 : 18;
    endfunction

    function automatic bit exp_err(input logic [15:0] base);
        return WRAP_ON && (int'(base) + 15 > 65535);
    endfunction

    task automatic do_op(input bit st, input logic [15:0] base, input logic [255:0] wd,
                         input int d_exp, input bit err_exp, input int p1, input int p2,
                         input bit hold, input int abort_at);
        logic [255:0] exp_rd;
        logic [255:0] act;
        logic [15:0]  a;
        int           last;
        exp_rd = last_rd;
        if (!st)
            for (int i = 0; i < 16; i++) exp_rd[16*i +: 16] = ref_mem[16'(int'(base) + i)];
        bus.start     = 1'b1;
        bus.is_store  = st;
        bus.base_addr = base;
        bus.wdata     = wd;
        tick();
        if (!hold) begin
            bus.start = 1'b0;
        end else begin
            bus.is_store  = 1'($urandom);
            bus.base_addr = 16'($urandom);
            bus.wdata     = {8{32'($urandom)}};
        end
        last = hold ? d_exp + 1 : d_exp + 3;
        for (int c = 1; c <= last; c++) begin
            if (c > 1) tick();
            a = 16'(int'(base) + c - 1);
            chk($sformatf("ctl c%0d", c),
                {bus.busy, bus.done, bus.mem_we, bus.mem_re, bus.err},
                {c <= d_exp, c == d_exp, st && c <= 16, !st && c <= 16, err_exp && c == d_exp});
            if (c <= 16) chk($sformatf("addr c%0d", c), bus.mem_addr, a);
            if (st && c <= 16) chk($sformatf("wdata c%0d", c), bus.mem_wdata, wd[16*(c-1) +: 16]);
            if (c == d_exp) chk(st ? "rdata held at done" : "rdata at done", bus.rdata, exp_rd);
            if (c == last) chk("rdata held after", bus.rdata, exp_rd);
            if (c == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort ctl", {bus.busy, bus.done, bus.mem_we, bus.mem_re, bus.err}, 0);
                chk("abort addr/wdata", {bus.mem_addr, bus.mem_wdata}, 0);
                chk("abort rdata", bus.rdata, 0);
                last_rd = '0;
                tick();
                rst = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    chk("post-abort idle", {bus.busy, bus.done, bus.mem_we, bus.mem_re}, 0);
                end
                return;
            end
            if (c == p1 || c == p2) begin
                bus.start     = 1'b1;
                bus.is_store  = ~st;
                bus.base_addr = 16'($urandom);
            end else if (!hold) begin
                bus.start = 1'b0;
            end
        end
        if (st) begin
            for (int i = 0; i < 16; i++) act[16*i +: 16] = mem[16'(int'(base) + i)];
            chk("stored memory", act, wd);
            for (int i = 0; i < 16; i++) ref_mem[16'(int'(base) + i)] = wd[16*i +: 16];
        end else begin
            last_rd = exp_rd;
        end
    endtask

    initial begin
        logic [255:0] wd;
        logic [15:0]  base;
        bit           st;

        tbl[0] = '{1'b1, 16'h0100, 16'h3C00, 17, 1'b0};
        tbl[1] = '{1'b0, 16'h0100, 16'h3C00, 18, 1'b0};
        tbl[2] = '{1'b1, 16'hFFF8, 16'h1000, 17, WRAP_ON};
        tbl[3] = '{1'b0, 16'hFFF8, 16'h1000, 18, WRAP_ON};
        tbl[4] = '{1'b1, 16'hFFF0, 16'h2000, 17, 1'b0};
        tbl[5] = '{1'b0, 16'hFFF0, 16'h2000, 18, 1'b0};
        tbl[6] = '{1'b1, 16'hFFF1, 16'h4000, 17, WRAP_ON};
        tbl[7] = '{1'b0, 16'hFFF1, 16'h4000, 18, WRAP_ON};

        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'(i) ^ 16'h5A5A;
            ref_mem[i] = 16'(i) ^ 16'h5A5A;
        end
        last_rd       = '0;
        bus.start     = 1'b0;
        bus.is_store  = 1'b0;
        bus.base_addr = '0;
        bus.wdata     = '0;

        tick();
        tick();
        chk("reset ctl", {bus.busy, bus.done, bus.mem_we, bus.mem_re, bus.err}, 0);
        chk("reset addr/wdata", {bus.mem_addr, bus.mem_wdata}, 0);
        chk("reset rdata", bus.rdata, 0);
        rst = 1'b0;
        tick();

        for (int t = 0; t < 8; t++) begin
            do_op(tbl[t].st, tbl[t].base, pat_vec(tbl[t].pat), tbl[t].done_cyc, tbl[t].err, 0, 0, 1'b0, 0);
            if (!tbl[t].st) chk($sformatf("tbl%0d rdata", t), bus.rdata, pat_vec(tbl[t].pat));
        end

        // starts during an active op are dropped, not queued
        do_op(1'b1, 16'h0200, pat_vec(16'h7700), 17, 1'b0, 5, 17, 1'b0, 0);
        do_op(1'b0, 16'h0200, '0, 18, 1'b0, 5, 17, 1'b0, 0);
        chk("ignored-start load", bus.rdata, pat_vec(16'h7700));

        // start held high: each op accepted after a single idle cycle
        do_op(1'b1, 16'h0300, pat_vec(16'h1111), 17, 1'b0, 0, 0, 1'b1, 0);
        do_op(1'b1, 16'h0310, pat_vec(16'h2222), 17, 1'b0, 0, 0, 1'b1, 0);
        do_op(1'b0, 16'h0300, '0, 18, 1'b0, 0, 0, 1'b1, 0);
        do_op(1'b0, 16'h0310, '0, 18, 1'b0, 0, 0, 1'b0, 0);
        chk("back-to-back load", bus.rdata, pat_vec(16'h2222));

        // reset during a load, then the same load runs cleanly
        do_op(1'b0, 16'h0100, '0, 18, 1'b0, 0, 0, 1'b0, 8);
        do_op(1'b0, 16'h0100, '0, 18, 1'b0, 0, 0, 1'b0, 0);
        chk("reload after abort", bus.rdata, pat_vec(16'h3C00));

        for (int n = 0; n < 24; n++) begin
            st = 1'($urandom);
            if ($urandom_range(0, 3) == 0) base = 16'(16'hFFE8 + 16'($urandom_range(0, 31)));
            else base = 16'($urandom);
            for (int i = 0; i < 16; i++) wd[16*i +: 16] = 16'($urandom);
            do_op(st, base, wd, exp_done(st), exp_err(base), 0, 0, 1'b0, 0);
            do_op(1'b0, base, '0, 18, exp_err(base), 0, 0, 1'b0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
